// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: FSM state encoding and default sizing shared by the accumulator scheduler
package acc_sched_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam int DW_DEF      = 16;
  localparam int VEC_LEN_DEF = 136;
endpackage

// File: rtl/acc_sched_rr_arb.sv
// rr_arb: combinational round-robin pick; req/last_winner in, one-hot win out (search starts at last_winner+1)
module rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_winner,
  output logic [N-1:0]         win
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] idx;
  // walk from farthest to nearest so the nearest active requester after last_winner wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(last_winner) + k) % N);
      if (req[idx]) win = N'(1) << idx;
    end
  end
endmodule

// File: rtl/acc_sched.sv
// acc_sched: round-robin shared accumulator; req/gnt arbitration, data_in/in_valid/in_ready beats, sum_out/sum_id/sum_ovf/out_valid/out_ready result, busy
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int VEC_LEN = VEC_LEN_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  input  logic [N_REQ*DW-1:0]      data_in,
  input  logic [N_REQ-1:0]         in_valid,
  output logic [N_REQ-1:0]         in_ready,
  output logic [DW-1:0]            sum_out,
  output logic [$clog2(N_REQ)-1:0] sum_id,
  output logic                     sum_ovf,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(VEC_LEN);
  state_t state, state_nxt;
  logic [N_REQ-1:0] win;
  logic [IW-1:0] wid, win_id, last_winner;
  logic [DW-1:0] acc, lane, sum_nxt;
  logic [CW-1:0] cnt;
  logic ovf, fire, add_ovf, last_beat;
  rr_arb #(.N(N_REQ)) u_arb (.req(req), .last_winner(last_winner), .win(win));
  always_comb begin
    win_id = '0;
    lane   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win[i]) win_id = IW'(i);
      if (wid == IW'(i)) lane = data_in[i*DW +: DW];
    end
  end
  assign in_ready  = (state == ACCUM) ? gnt : '0;
  assign fire      = |(in_valid & in_ready);
  assign sum_nxt   = acc + lane;
  // two's-complement overflow: same-sign operands, result sign differs
  assign add_ovf   = (acc[DW-1] == lane[DW-1]) && (sum_nxt[DW-1] != acc[DW-1]);
  assign last_beat = fire && (cnt == CW'(VEC_LEN - 1));
  assign busy      = state != IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = ACCUM;
      ACCUM:   if (last_beat) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      wid         <= '0;
      acc         <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      sum_out     <= '0;
      sum_id      <= '0;
      sum_ovf     <= 1'b0;
      last_winner <= IW'(N_REQ - 1);
    end else begin
      if (state == IDLE && |req) begin
        gnt <= win;
        wid <= win_id;
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end
      if (fire) begin
        acc <= sum_nxt;
        cnt <= cnt + 1'b1;
        ovf <= ovf | add_ovf;
      end
      if (last_beat) begin
        gnt     <= '0;
        sum_out <= sum_nxt;
        sum_id  <= wid;
        sum_ovf <= ovf | add_ovf;
      end
      if (state == DONE && out_ready) last_winner <= wid;
    end
  end
endmodule

// File: tb/tb_acc_sched.sv
// tb_acc_sched: directed self-checking bench for acc_sched
module tb_acc_sched;
  logic clk = 0, rst_n = 0;
  logic [3:0] req = '0, gnt, in_valid = '0, in_ready;
  logic [63:0] data_in = '0;
  logic [15:0] sum_out;
  logic [1:0] sum_id;
  logic sum_ovf, out_valid, out_ready = 0, busy;
  int n_chk = 0, n_fail = 0, bad_rdy = 0;
  always #5 clk = ~clk;
  acc_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .data_in(data_in),
    .in_valid(in_valid), .in_ready(in_ready), .sum_out(sum_out), .sum_id(sum_id),
    .sum_ovf(sum_ovf), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 0; req = '0; in_valid = '0; out_ready = 0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_rdy", 32'(in_ready), 0);
    check("rst_ov", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", 32'({sum_ovf, sum_id, sum_out}), 0);
    rst_n = 1;
  endtask
  task automatic wait_gnt();
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (gnt == 0 && n < 20);
  endtask
  task automatic stream(input int lane, input logic [15:0] val, input bit toggle, input int beats, output int got);
    int cyc = 0;
    bit ph = 1, xfer;
    got = 0;
    data_in[lane*16 +: 16] = val;
    while (got < beats && cyc < 2000) begin
      in_valid[lane] = toggle ? ph : 1'b1;
      ph = ~ph;
      if ((in_ready & ~(4'b1 << lane)) != 0) bad_rdy++;
      xfer = in_valid[lane] && in_ready[lane];
      @(posedge clk); #1;
      if (xfer) got++;
      cyc++;
    end
    in_valid[lane] = 0;
  endtask
  initial begin
    int got;
    logic [3:0] exp_g;
    // lane0 streams 136 ones; req dropped mid-burst is ignored
    do_reset();
    @(posedge clk); #1;
    req = 4'b0001;
    check("gnt_pre", 32'(gnt), 0);
    @(posedge clk); #1;
    check("gnt_lat", 32'(gnt), 4'b0001);
    check("busy_acc", 32'(busy), 1);
    req = 4'b0000;
    stream(0, 16'h0001, 0, 135, got);
    check("ov_early", 32'(out_valid), 0);
    stream(0, 16'h0001, 0, 1, got);
    check("ov_lat", 32'(out_valid), 1);
    check("s1_sum", 32'(sum_out), 16'h0088);
    check("s1_id", 32'(sum_id), 0);
    check("s1_ovf", 32'(sum_ovf), 0);
    check("s1_gnt0", 32'(gnt), 0);
    check("s1_rdy0", 32'(in_ready), 0);
    // all four request continuously: order 0,1,2,3,0 with a bubble each time
    do_reset();
    out_ready = 1; req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt();
      exp_g = 4'b1 << (k % 4);
      check("rr_gnt", 32'(gnt), 32'(exp_g));
      stream(k % 4, 16'((k % 4) + 1), 0, 136, got);
      check("rr_sum", 32'(sum_out), 136 * ((k % 4) + 1));
      check("rr_id", 32'(sum_id), k % 4);
      @(posedge clk); #1;
      check("rr_bubble", 32'({busy, gnt}), 0);
    end
    // 0x7FFF wraps to 0xFF78 with overflow
    do_reset();
    req = 4'b0010;
    wait_gnt();
    check("ovf_gnt", 32'(gnt), 4'b0010);
    stream(1, 16'h7FFF, 0, 136, got);
    check("ovf_sum", 32'(sum_out), 16'hFF78);
    check("ovf_flag", 32'(sum_ovf), 1);
    check("ovf_id", 32'(sum_id), 1);
    // lane0 toggling, lane2 valid throughout but never granted
    do_reset();
    req = 4'b0001;
    wait_gnt();
    data_in[47:32] = 16'h1234;
    in_valid[2] = 1;
    bad_rdy = 0;
    stream(0, 16'h0003, 1, 136, got);
    check("tog_beats", 32'(got), 136);
    check("tog_lane2", 32'(bad_rdy), 0);
    check("tog_sum", 32'(sum_out), 16'h0198);
    check("tog_ovf", 32'(sum_ovf), 0);
    in_valid[2] = 0;
    // stall in DONE for 10 cycles, then release
    req = 4'b1111;
    bad_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1 || sum_out !== 16'h0198 || sum_id !== 0 || gnt !== 0 || busy !== 1) bad_rdy++;
    end
    check("hold_stable", 32'(bad_rdy), 0);
    out_ready = 1;
    @(posedge clk); #1;
    check("rel_idle", 32'({busy, out_valid, gnt}), 0);
    @(posedge clk); #1;
    check("rel_gnt", 32'(gnt), 4'b0010);
    // reset at beat 60 discards the partial sum
    do_reset();
    out_ready = 1; req = 4'b0001;
    wait_gnt();
    stream(0, 16'h0005, 0, 60, got);
    check("mid_beats", 32'(got), 60);
    rst_n = 0;
    #1;
    check("mid_rst", 32'({busy, out_valid, gnt, in_ready}), 0);
    @(posedge clk); #1;
    rst_n = 1;
    check("mid_ov", 32'(out_valid), 0);
    wait_gnt();
    check("mid_gnt", 32'(gnt), 4'b0001);
    stream(0, 16'h0001, 0, 136, got);
    check("mid_sum", 32'(sum_out), 16'h0088);
    check("mid_ov2", 32'(out_valid), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
